// File: rtl/lsu_pkg.sv
// Shared core types: ALU op codes, LSU access types, LSU FSM states and helpers.
package lsu_pkg;

  // ALU operation select, shared with the execute stage.
  typedef enum logic [3:0] {
    AluAdd  = 4'd0,
    AluSub  = 4'd1,
    AluAnd  = 4'd2,
    AluOr   = 4'd3,
    AluXor  = 4'd4,
    AluSll  = 4'd5,
    AluSrl  = 4'd6,
    AluSra  = 4'd7,
    AluSlt  = 4'd8,
    AluSltu = 4'd9
  } alu_op_e;

  // Load/store access type. Loads keep their funct3 code, stores fill the gaps.
  typedef enum logic [2:0] {
    LsuLb  = 3'b000,
    LsuLh  = 3'b001,
    LsuLw  = 3'b010,
    LsuSb  = 3'b011,
    LsuLbu = 3'b100,
    LsuLhu = 3'b101,
    LsuSh  = 3'b110,
    LsuSw  = 3'b111
  } lsu_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } lsu_state_e;

  function automatic logic lsu_is_load(lsu_type_e t);
    return (t == LsuLb) || (t == LsuLh) || (t == LsuLw) || (t == LsuLbu) || (t == LsuLhu);
  endfunction

  // Any type that does not decode (e.g. X on the input) is reported as a fault.
  function automatic logic lsu_is_misaligned(lsu_type_e t, logic [1:0] addr_lo);
    logic r;
    case (t)
      LsuLb, LsuLbu, LsuSb: r = 1'b0;
      LsuLh, LsuLhu, LsuSh: r = addr_lo[0];
      LsuLw, LsuSw:         r = (addr_lo != 2'b00);
      default:              r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-addressed memory bus between the LSU (master) and data memory (slave).
interface lsu_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            wstrb;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/replication and load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_type_e   i_type,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store lanes: replicate the narrow datum across the word and strobe only its lanes.
  always_comb begin
    o_wstrb = 4'b0000;
    o_wdata = i_wdata;
    case (i_type)
      LsuSb: begin
        o_wstrb = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      LsuSh: begin
        o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      LsuSw:   o_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Load lanes: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    w_byte  = i_rdata[7:0];
    w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_ldata = 32'h0;
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: ;
    endcase
    case (i_type)
      LsuLb:   o_ldata = {{24{w_byte[7]}}, w_byte};
      LsuLbu:  o_ldata = {24'h0, w_byte};
      LsuLh:   o_ldata = {{16{w_half[15]}}, w_half};
      LsuLhu:  o_ldata = {16'h0, w_half};
      LsuLw:   o_ldata = i_rdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one memory op at a time and runs it over a req/gnt/rvalid bus.
// Only DATA_WIDTH = 32 is supported (four byte lanes).
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_lsu_valid,
  output logic                  o_lsu_ready,
  input  logic [2:0]            i_lsu_type,
  input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
  input  logic [DATA_WIDTH-1:0] i_lsu_wdata,
  input  logic [4:0]            i_lsu_rd,
  output logic                  o_lsu_done,
  output logic                  o_lsu_wb_en,
  output logic [4:0]            o_lsu_wb_rd,
  output logic [DATA_WIDTH-1:0] o_lsu_wb_data,
  output logic                  o_lsu_misalign,
  lsu_if.master                 mem
);

  lsu_state_e            r_state, w_state_next;
  lsu_type_e             r_type;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [4:0]            r_rd;
  logic                  r_misalign;

  lsu_type_e             w_in_type;
  logic                  w_accept;
  logic                  w_in_misalign;
  logic                  w_is_load;
  logic                  w_req;
  logic                  w_done;
  logic [3:0]            w_wstrb;
  logic [31:0]           w_wdata;
  logic [31:0]           w_ldata;

  assign w_in_type     = lsu_type_e'(i_lsu_type);
  assign w_accept      = i_lsu_valid && (r_state == StIdle);
  assign w_in_misalign = lsu_is_misaligned(w_in_type, i_lsu_addr[1:0]);
  assign w_is_load     = lsu_is_load(r_type);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Next state: faults skip the bus; rvalid only counts once the grant is behind us.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (w_accept) w_state_next = w_in_misalign ? StDone : StReq;
      StReq:  if (mem.gnt) w_state_next = StWait;
      StWait: if (mem.rvalid) w_state_next = StDone;
      StDone: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Op latch on accept, read data capture on the response.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_type     <= LsuLb;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd       <= 5'd0;
      r_misalign <= 1'b0;
      r_rdata    <= '0;
    end else begin
      if (w_accept) begin
        r_type     <= w_in_type;
        r_addr     <= i_lsu_addr;
        r_wdata    <= i_lsu_wdata;
        r_rd       <= i_lsu_rd;
        r_misalign <= w_in_misalign;
      end
      if ((r_state == StWait) && mem.rvalid) r_rdata <= mem.rdata;
    end
  end

  lsu_align u_align (
    .i_type    (r_type),
    .i_addr_lo (r_addr[1:0]),
    .i_wdata   (r_wdata),
    .i_rdata   (r_rdata),
    .o_wstrb   (w_wstrb),
    .o_wdata   (w_wdata),
    .o_ldata   (w_ldata)
  );

  assign w_req  = (r_state == StReq);
  assign w_done = (r_state == StDone);

  // Bus fields are zero outside a request so nothing stale leaks onto the bus.
  assign mem.req   = w_req;
  assign mem.we    = w_req && !w_is_load;
  assign mem.addr  = w_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign mem.wstrb = (w_req && !w_is_load) ? w_wstrb : 4'b0000;
  assign mem.wdata = (w_req && !w_is_load) ? w_wdata : '0;

  assign o_lsu_ready    = (r_state == StIdle);
  assign o_lsu_done     = w_done;
  assign o_lsu_misalign = w_done && r_misalign;
  assign o_lsu_wb_en    = w_done && w_is_load && !r_misalign;
  assign o_lsu_wb_rd    = o_lsu_wb_en ? r_rd : 5'd0;
  assign o_lsu_wb_data  = o_lsu_wb_en ? w_ldata : '0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU; the bench plays the memory side of the bus.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [2:0]  typ;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        done;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_lsu_valid    (valid),
    .o_lsu_ready    (ready),
    .i_lsu_type     (typ),
    .i_lsu_addr     (addr),
    .i_lsu_wdata    (wdata),
    .i_lsu_rd       (rd),
    .o_lsu_done     (done),
    .o_lsu_wb_en    (wb_en),
    .o_lsu_wb_rd    (wb_rd),
    .o_lsu_wb_data  (wb_data),
    .o_lsu_misalign (misalign),
    .mem            (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an op for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] r);
    valid = 1'b1;
    typ   = t;
    addr  = a;
    wdata = d;
    rd    = r;
    step();
    valid = 1'b0;
    typ   = 3'd0;
    addr  = 32'h0;
    wdata = 32'h0;
    rd    = 5'd0;
  endtask

  // From REQ: grant at once, respond next cycle; returns in the DONE cycle.
  task automatic serve(input logic [31:0] rdat);
    bus.gnt = 1'b1;
    step();
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata  = rdat;
    step();
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;
  endtask

  initial begin
    rst_n      = 1'b0;
    valid      = 1'b0;
    typ        = 3'd0;
    addr       = 32'h0;
    wdata      = 32'h0;
    rd         = 5'd0;
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata  = 32'h0;

    // Reset state
    step();
    step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bus_addr", bus.addr, 32'h0);
    check("rst_wstrb", 32'(bus.wstrb), 32'h0);
    rst_n = 1'b1;
    step();

    // SW 0x100: accept, REQ, WAIT, DONE on the third cycle after accept
    issue(LsuSw, 32'h0000_0100, 32'hDEAD_BEEF, 5'd1);
    check("sw_req", 32'(bus.req), 32'd1);
    check("sw_ready", 32'(ready), 32'd0);
    check("sw_we", 32'(bus.we), 32'd1);
    check("sw_addr", bus.addr, 32'h0000_0100);
    check("sw_wstrb", 32'(bus.wstrb), 32'hF);
    check("sw_wdata", bus.wdata, 32'hDEAD_BEEF);
    bus.gnt = 1'b1;
    step();
    bus.gnt = 1'b0;
    check("sw_wait_no_done", 32'(done), 32'd0);
    check("sw_wait_no_req", 32'(bus.req), 32'd0);
    bus.rvalid = 1'b1;
    step();
    bus.rvalid = 1'b0;
    check("sw_done", 32'(done), 32'd1);
    check("sw_wb_en", 32'(wb_en), 32'd0);
    check("sw_wb_data", wb_data, 32'h0);
    check("sw_misalign", 32'(misalign), 32'd0);
    step();
    check("sw_done_one_cycle", 32'(done), 32'd0);
    check("sw_back_idle", 32'(ready), 32'd1);

    // LB 0x203: rvalid in the grant cycle must be ignored
    issue(LsuLb, 32'h0000_0203, 32'h0, 5'd7);
    check("lb_addr", bus.addr, 32'h0000_0200);
    check("lb_we", 32'(bus.we), 32'd0);
    check("lb_wstrb", 32'(bus.wstrb), 32'h0);
    bus.gnt    = 1'b1;
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h1111_1111;
    step();
    bus.gnt    = 1'b0;
    bus.rvalid = 1'b0;
    step();
    check("lb_gnt_rvalid_ignored", 32'(done), 32'd0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'h8011_2233;
    step();
    bus.rvalid = 1'b0;
    check("lb_done", 32'(done), 32'd1);
    check("lb_wb_en", 32'(wb_en), 32'd1);
    check("lb_wb_rd", 32'(wb_rd), 32'd7);
    check("lb_wb_data", wb_data, 32'hFFFF_FF80);
    step();
    check("lb_wb_data_cleared", wb_data, 32'h0);

    // LBU 0x203
    issue(LsuLbu, 32'h0000_0203, 32'h0, 5'd8);
    serve(32'h8011_2233);
    check("lbu_wb_data", wb_data, 32'h0000_0080);
    check("lbu_wb_rd", 32'(wb_rd), 32'd8);
    step();

    // LH upper half, LHU lower half, LW
    issue(LsuLh, 32'h0000_0302, 32'h0, 5'd9);
    serve(32'h8011_2233);
    check("lh_wb_data", wb_data, 32'hFFFF_8011);
    step();
    issue(LsuLhu, 32'h0000_0300, 32'h0, 5'd10);
    serve(32'hA011_F233);
    check("lhu_wb_data", wb_data, 32'h0000_F233);
    step();
    issue(LsuLw, 32'h0000_0304, 32'h0, 5'd11);
    serve(32'h8011_2233);
    check("lw_wb_data", wb_data, 32'h8011_2233);
    step();

    // LH 0x301: fault one cycle after accept, no bus request
    issue(LsuLh, 32'h0000_0301, 32'h0, 5'd12);
    check("lh_mis_done", 32'(done), 32'd1);
    check("lh_mis_flag", 32'(misalign), 32'd1);
    check("lh_mis_no_req", 32'(bus.req), 32'd0);
    check("lh_mis_wb_en", 32'(wb_en), 32'd0);
    check("lh_mis_wb_data", wb_data, 32'h0);
    step();
    check("lh_mis_flag_clear", 32'(misalign), 32'd0);
    check("lh_mis_idle_no_req", 32'(bus.req), 32'd0);
    check("lh_mis_ready", 32'(ready), 32'd1);

    // SW 0x102: word misaligned
    issue(LsuSw, 32'h0000_0102, 32'h1234_5678, 5'd0);
    check("sw_mis_flag", 32'(misalign), 32'd1);
    check("sw_mis_no_req", 32'(bus.req), 32'd0);
    step();

    // SH 0x402 with grant withheld for 4 cycles
    issue(LsuSh, 32'h0000_0402, 32'h0000_ABCD, 5'd0);
    for (int i = 0; i < 4; i++) begin
      check("sh_hold_req", 32'(bus.req), 32'd1);
      check("sh_hold_addr", bus.addr, 32'h0000_0400);
      check("sh_hold_wstrb", 32'(bus.wstrb), 32'hC);
      check("sh_hold_wdata", bus.wdata, 32'hABCD_ABCD);
      check("sh_hold_ready", 32'(ready), 32'd0);
      step();
    end
    check("sh_still_req", 32'(bus.req), 32'd1);
    serve(32'h0);
    check("sh_done", 32'(done), 32'd1);
    check("sh_wb_en", 32'(wb_en), 32'd0);
    step();

    // SB 0x501: byte lane 1
    issue(LsuSb, 32'h0000_0501, 32'h1234_5677, 5'd0);
    check("sb_wstrb", 32'(bus.wstrb), 32'h2);
    check("sb_wdata", bus.wdata, 32'h7777_7777);
    serve(32'h0);
    check("sb_done", 32'(done), 32'd1);
    step();

    // Reset while in WAIT, then a late response
    issue(LsuLw, 32'h0000_0600, 32'h0, 5'd3);
    bus.gnt = 1'b1;
    step();
    bus.gnt = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_req", 32'(bus.req), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_wb_en", 32'(wb_en), 32'd0);
    check("mid_rst_misalign", 32'(misalign), 32'd0);
    bus.rvalid = 1'b1;
    bus.rdata  = 32'hFFFF_FFFF;
    step();
    check("rst_rvalid_no_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();
    bus.rvalid = 1'b0;
    check("post_rst_no_done", 32'(done), 32'd0);
    check("post_rst_wb_data", wb_data, 32'h0);
    step();
    check("post_rst_still_idle", 32'(ready), 32'd1);
    check("post_rst_no_done2", 32'(done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
